// File: rtl/tsqr_tile_feeder.sv
// tsqr_tile_feeder
//   Streams tile_no tiles of ROWS rows each from a source memory to NCORE
//   TSQR cores. Tile k goes to core k mod NCORE. Each core may hold at most
//   two unconsumed tiles; a credit is returned by a core_fi pulse.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   start, tile_no               run request and tile count (sampled together)
//   src_en, src_addr             source read request (data arrives 1 cycle later)
//   src_ug/src_pg/src_e_*        source row data and per-row scalars
//   ug_o/pg_o/e_*_o              registered outputs, zero when no row is valid
//   row_vld, e_vld               one-hot per-core valid strobes
//   core_fi                      per-core tile-consumed pulses
//   busy, done, tile_cnt         run status
module tsqr_tile_feeder #(
  parameter int ROW_W  = 512,
  parameter int ROWS   = 8,
  parameter int NCORE  = 2,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  tile_no,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [ROW_W-1:0]  src_ug,
  input  logic [ROW_W-1:0]  src_pg,
  input  logic [31:0]       src_e_ug,
  input  logic [31:0]       src_e_pg,
  input  logic [31:0]       src_e_upg,
  output logic [ROW_W-1:0]  ug_o,
  output logic [ROW_W-1:0]  pg_o,
  output logic [31:0]       e_ug_o,
  output logic [31:0]       e_pg_o,
  output logic [31:0]       e_upg_o,
  output logic [NCORE-1:0]  row_vld,
  output logic [NCORE-1:0]  e_vld,
  input  logic [NCORE-1:0]  core_fi,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tile_cnt
);

  localparam int CORE_W = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int ROW_CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, READ, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    tile_no_reg;
  logic [CNT_W-1:0]    k_reg;
  logic [ROW_CW-1:0]   row_reg;
  logic [CORE_W-1:0]   core_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [NCORE-1:0]    credit_nz;

  // Stage 1: request metadata aligned with the returning source data
  logic                p1_vld_reg, p1_e_reg, p1_last_reg, p1_final_reg;
  logic [CORE_W-1:0]   p1_core_reg;
  logic [NCORE-1:0]    p1_onehot;

  // Stage 2: output registers
  logic [ROW_W-1:0]    ug_reg, pg_reg;
  logic [31:0]         e_ug_reg, e_pg_reg, e_upg_reg;
  logic [NCORE-1:0]    row_vld_reg, e_vld_reg;
  logic                final_reg;
  logic [CNT_W-1:0]    tile_cnt_reg;

  logic                accept, has_credit, tile_issue, issue, last_row, more, first_round;
  logic [ROW_CW-1:0]   row_cur;

  assign accept      = (state_reg == IDLE) && start;
  assign has_credit  = credit_nz[core_reg];
  // CHECK issues row 0 itself, so tile-to-tile chaining costs no cycle
  assign tile_issue  = (state_reg == CHECK) && has_credit;
  assign issue       = tile_issue || (state_reg == READ);
  assign row_cur     = (state_reg == CHECK) ? '0 : row_reg;
  assign last_row    = (row_cur == ROW_CW'(ROWS - 1));
  assign more        = ({1'b0, k_reg} + (CNT_W + 1)'(1)) < {1'b0, tile_no_reg};
  assign first_round = {1'b0, k_reg} < (CNT_W + 1)'(NCORE);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (tile_no == '0) ? DONE : CHECK;
      CHECK: if (has_credit) state_next = last_row ? (more ? CHECK : DRAIN) : READ;
      READ:  if (last_row) state_next = more ? CHECK : DRAIN;
      DRAIN: if (final_reg) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign src_en   = issue;
  assign src_addr = issue ? addr_reg : '0;
  assign busy     = (state_reg == CHECK) || (state_reg == READ) || (state_reg == DRAIN);
  assign done     = (state_reg == DONE);

  // Tile / row / core / address bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_no_reg <= '0;
      k_reg       <= '0;
      row_reg     <= '0;
      core_reg    <= '0;
      addr_reg    <= '0;
    end else if (accept) begin
      tile_no_reg <= tile_no;
      k_reg       <= '0;
      row_reg     <= '0;
      core_reg    <= '0;
      addr_reg    <= '0;
    end else if (issue) begin
      addr_reg <= addr_reg + ADDR_W'(1);
      if (last_row) begin
        row_reg  <= '0;
        k_reg    <= k_reg + CNT_W'(1);
        core_reg <= (core_reg == CORE_W'(NCORE - 1)) ? '0 : core_reg + CORE_W'(1);
      end else begin
        row_reg  <= row_cur + ROW_CW'(1);
      end
    end
  end

  // Per-core credits: 2 on start, -1 per issued tile, +1 per core_fi (max 2)
  generate
    for (genvar gi = 0; gi < NCORE; gi++) begin : g_credit
      logic [1:0] credit_reg;
      logic       consume, fi_ok;
      assign consume       = tile_issue && (core_reg == CORE_W'(gi));
      assign fi_ok         = core_fi[gi] && (state_reg != IDLE);
      assign credit_nz[gi] = (credit_reg != 2'd0);
      assign p1_onehot[gi] = (p1_core_reg == CORE_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          credit_reg <= 2'd0;
        end else if (accept) begin
          credit_reg <= 2'd2;
        end else if (consume && !fi_ok) begin
          credit_reg <= credit_reg - 2'd1;
        end else if (fi_ok && !consume && credit_reg != 2'd2) begin
          credit_reg <= credit_reg + 2'd1;
        end
      end
    end
  endgenerate

  // Two-stage data path: source data is captured the cycle after src_en
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld_reg   <= 1'b0;
      p1_e_reg     <= 1'b0;
      p1_last_reg  <= 1'b0;
      p1_final_reg <= 1'b0;
      p1_core_reg  <= '0;
      ug_reg       <= '0;
      pg_reg       <= '0;
      e_ug_reg     <= '0;
      e_pg_reg     <= '0;
      e_upg_reg    <= '0;
      row_vld_reg  <= '0;
      e_vld_reg    <= '0;
      final_reg    <= 1'b0;
      tile_cnt_reg <= '0;
    end else begin
      p1_vld_reg   <= issue;
      p1_e_reg     <= first_round;
      p1_last_reg  <= last_row;
      p1_final_reg <= last_row && !more;
      p1_core_reg  <= core_reg;
      ug_reg       <= p1_vld_reg ? src_ug    : '0;
      pg_reg       <= p1_vld_reg ? src_pg    : '0;
      e_ug_reg     <= p1_vld_reg ? src_e_ug  : '0;
      e_pg_reg     <= p1_vld_reg ? src_e_pg  : '0;
      e_upg_reg    <= p1_vld_reg ? src_e_upg : '0;
      row_vld_reg  <= p1_vld_reg ? p1_onehot : '0;
      e_vld_reg    <= (p1_vld_reg && p1_e_reg) ? p1_onehot : '0;
      final_reg    <= p1_vld_reg && p1_final_reg;
      if (accept)
        tile_cnt_reg <= '0;
      else if (p1_vld_reg && p1_last_reg)
        tile_cnt_reg <= tile_cnt_reg + CNT_W'(1);
    end
  end

  assign ug_o     = ug_reg;
  assign pg_o     = pg_reg;
  assign e_ug_o   = e_ug_reg;
  assign e_pg_o   = e_pg_reg;
  assign e_upg_o  = e_upg_reg;
  assign row_vld  = row_vld_reg;
  assign e_vld    = e_vld_reg;
  assign tile_cnt = tile_cnt_reg;

endmodule

// File: tb/tb_tsqr_tile_feeder.sv
// Bench for tsqr_tile_feeder: one NCORE=1 instance (u1) and one NCORE=2
// instance (u2). Expected rows (cycle, address, core, scalar flag) are queued
// before each run and popped by per-instance monitors on every row_vld.
module tb_tsqr_tile_feeder;

  localparam int RW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    int addr;
    int core;
    bit e;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  function automatic logic [63:0] f_ug(int a);
    return {32'hC0DE_0000 ^ 32'(a), 32'h1357_0000 + 32'(a)};
  endfunction
  function automatic logic [63:0] f_pg(int a);
    return {32'h2468_0000 + 32'(a), ~32'(a)};
  endfunction
  function automatic logic [31:0] f_e(int a, int sel);
    return 32'hE000_0000 + 32'(sel) * 32'h0100_0000 + 32'(a);
  endfunction

  // ---------------- u1 : NCORE = 1 ----------------
  logic            rst1 = 1'b1, start1 = 1'b0, fi1 = 1'b0;
  logic [15:0]     tn1 = '0;
  logic            src_en1, rv1, ev1, busy1, done1;
  logic [11:0]     addr1;
  logic [RW-1:0]   sug1, spg1, ug1, pg1;
  logic [31:0]     seu1, sep1, seup1, eu1, ep1, eup1;
  logic [15:0]     cnt1;

  tsqr_tile_feeder #(.ROW_W(RW), .ROWS(8), .NCORE(1), .CNT_W(16), .ADDR_W(12)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .tile_no(tn1),
    .src_en(src_en1), .src_addr(addr1),
    .src_ug(sug1), .src_pg(spg1), .src_e_ug(seu1), .src_e_pg(sep1), .src_e_upg(seup1),
    .ug_o(ug1), .pg_o(pg1), .e_ug_o(eu1), .e_pg_o(ep1), .e_upg_o(eup1),
    .row_vld(rv1), .e_vld(ev1), .core_fi(fi1),
    .busy(busy1), .done(done1), .tile_cnt(cnt1)
  );

  // ---------------- u2 : NCORE = 2 ----------------
  logic            rst2 = 1'b1, start2 = 1'b0;
  logic [1:0]      fi2 = '0;
  logic [15:0]     tn2 = '0;
  logic            src_en2, busy2, done2;
  logic [1:0]      rv2, ev2;
  logic [11:0]     addr2;
  logic [RW-1:0]   sug2, spg2, ug2, pg2;
  logic [31:0]     seu2, sep2, seup2, eu2, ep2, eup2;
  logic [15:0]     cnt2;

  tsqr_tile_feeder #(.ROW_W(RW), .ROWS(8), .NCORE(2), .CNT_W(16), .ADDR_W(12)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .tile_no(tn2),
    .src_en(src_en2), .src_addr(addr2),
    .src_ug(sug2), .src_pg(spg2), .src_e_ug(seu2), .src_e_pg(sep2), .src_e_upg(seup2),
    .ug_o(ug2), .pg_o(pg2), .e_ug_o(eu2), .e_pg_o(ep2), .e_upg_o(eup2),
    .row_vld(rv2), .e_vld(ev2), .core_fi(fi2),
    .busy(busy2), .done(done2), .tile_cnt(cnt2)
  );

  // Source memories: one-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    if (src_en1) begin
      sug1 <= f_ug(int'(addr1)); spg1 <= f_pg(int'(addr1));
      seu1 <= f_e(int'(addr1), 1); sep1 <= f_e(int'(addr1), 2); seup1 <= f_e(int'(addr1), 3);
    end else begin
      sug1 <= {RW{1'b1}}; spg1 <= 64'hDEAD_BEEF_DEAD_BEEF;
      seu1 <= 32'hBAD0_0001; sep1 <= 32'hBAD0_0002; seup1 <= 32'hBAD0_0003;
    end
    if (src_en2) begin
      sug2 <= f_ug(int'(addr2)); spg2 <= f_pg(int'(addr2));
      seu2 <= f_e(int'(addr2), 1); sep2 <= f_e(int'(addr2), 2); seup2 <= f_e(int'(addr2), 3);
    end else begin
      sug2 <= {RW{1'b1}}; spg2 <= 64'hDEAD_BEEF_DEAD_BEEF;
      seu2 <= 32'hBAD0_0001; sep2 <= 32'hBAD0_0002; seup2 <= 32'hBAD0_0003;
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp_row(string tag, exp_t e, logic [1:0] rv, logic [1:0] ev,
                         logic [63:0] ug, logic [63:0] pg,
                         logic [31:0] eu, logic [31:0] ep, logic [31:0] eup);
    logic [63:0] oh;
    oh = 64'd1 << e.core;
    chk({tag, " row cycle"}, 64'(cyc), 64'(e.cyc));
    chk({tag, " row_vld"}, 64'(rv), oh);
    chk({tag, " e_vld"}, 64'(ev), e.e ? oh : 64'd0);
    chk({tag, " ug_o"}, ug, f_ug(e.addr));
    chk({tag, " pg_o"}, pg, f_pg(e.addr));
    chk({tag, " e_ug_o"}, 64'(eu), 64'(f_e(e.addr, 1)));
    chk({tag, " e_pg_o"}, 64'(ep), 64'(f_e(e.addr, 2)));
    chk({tag, " e_upg_o"}, 64'(eup), 64'(f_e(e.addr, 3)));
  endtask

  task automatic cmp_idle(string tag, logic [1:0] ev, logic [63:0] ug, logic [63:0] pg,
                          logic [31:0] eu, logic [31:0] ep, logic [31:0] eup);
    chk({tag, " idle e_vld"}, 64'(ev), 64'd0);
    chk({tag, " idle data"}, ug | pg | 64'(eu) | 64'(ep) | 64'(eup), 64'd0);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rv1 !== 1'b0) begin
      if (q1.size() == 0) chk("u1 unexpected row_vld", 64'(rv1), 64'd0);
      else cmp_row("u1", q1.pop_front(), 2'(rv1), 2'(ev1), ug1, pg1, eu1, ep1, eup1);
    end else begin
      cmp_idle("u1", 2'(ev1), ug1, pg1, eu1, ep1, eup1);
    end
    if (rv2 !== 2'b00) begin
      if (q2.size() == 0) chk("u2 unexpected row_vld", 64'(rv2), 64'd0);
      else cmp_row("u2", q2.pop_front(), rv2, ev2, ug2, pg2, eu2, ep2, eup2);
    end else begin
      cmp_idle("u2", ev2, ug2, pg2, eu2, ep2, eup2);
    end
  end

  // Advance to the falling edge inside cycle c
  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_tile(bit inst2, int k, int c0, int nrows = 8);
    exp_t e;
    for (int r = 0; r < nrows; r++) begin
      e.cyc  = c0 + r;
      e.addr = k * 8 + r;
      e.core = inst2 ? (k % 2) : 0;
      e.e    = inst2 ? (k < 2) : (k < 1);
      if (inst2) q2.push_back(e);
      else       q1.push_back(e);
    end
  endtask

  task automatic start_run(bit inst2, int n, int s);
    at(s);
    if (inst2) begin start2 = 1'b1; tn2 = 16'(n); end
    else       begin start1 = 1'b1; tn1 = 16'(n); end
    at(s + 1);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic pulse_fi(bit inst2, logic [1:0] mask, int c);
    at(c);
    if (inst2) fi2 = mask;
    else       fi1 = mask[0];
    at(c + 1);
    fi1 = 1'b0;
    fi2 = 2'b00;
  endtask

  task automatic check_end(bit inst2, int dc, int n);
    at(dc - 1);
    chk("pre-done done", 64'(inst2 ? done2 : done1), 64'd0);
    chk("pre-done busy", 64'(inst2 ? busy2 : busy1), 64'd1);
    at(dc);
    chk("done pulse", 64'(inst2 ? done2 : done1), 64'd1);
    chk("busy at done", 64'(inst2 ? busy2 : busy1), 64'd0);
    chk("tile_cnt", 64'(inst2 ? cnt2 : cnt1), 64'(n));
    at(dc + 1);
    chk("done single", 64'(inst2 ? done2 : done1), 64'd0);
    at(dc + 3);
    chk("tile_cnt hold", 64'(inst2 ? cnt2 : cnt1), 64'(n));
    chk("queue drained", 64'(inst2 ? q2.size() : q1.size()), 64'd0);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst src_en", 64'({src_en1, src_en2}), 64'd0);
    chk("rst busy", 64'({busy1, busy2}), 64'd0);
    chk("rst done", 64'({done1, done2}), 64'd0);
    chk("rst tile_cnt", 64'({cnt1, cnt2}), 64'd0);
    chk("rst src_addr", 64'({addr1, addr2}), 64'd0);
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Two tiles, one core: 16 back-to-back rows, scalars on the first tile
    s = cyc + 3;
    push_tile(0, 0, s + 3);
    push_tile(0, 1, s + 11);
    start_run(0, 2, s);
    chk("A busy after start", 64'(busy1), 64'd1);
    chk("A first src_en", 64'(src_en1), 64'd1);
    chk("A first src_addr", 64'(addr1), 64'd0);
    check_end(0, s + 19, 2);

    // tile_no = 0: done next cycle, nothing issued
    s = cyc + 3;
    start_run(0, 0, s);
    chk("Z done", 64'(done1), 64'd1);
    chk("Z busy", 64'(busy1), 64'd0);
    chk("Z src_en", 64'(src_en1), 64'd0);
    for (int i = 0; i < 4; i++) begin
      at(s + 2 + i);
      chk("Z quiet", 64'({busy1, src_en1, done1}), 64'd0);
    end

    // Four tiles, one core: fi in IDLE ignored, stalls after tiles 1 and 2
    s = cyc + 8;
    pulse_fi(0, 2'b01, s - 5);
    pulse_fi(0, 2'b01, s - 4);
    pulse_fi(0, 2'b01, s - 3);
    push_tile(0, 0, s + 3);
    push_tile(0, 1, s + 11);
    push_tile(0, 2, s + 33);
    push_tile(0, 3, s + 53);
    start_run(0, 4, s);
    at(s + 25);
    chk("B stall1 src_en", 64'(src_en1), 64'd0);
    chk("B stall1 busy", 64'(busy1), 64'd1);
    pulse_fi(0, 2'b01, s + 30);
    chk("B resume src_addr", 64'(addr1), 64'd16);
    at(s + 45);
    chk("B stall2 src_en", 64'(src_en1), 64'd0);
    pulse_fi(0, 2'b01, s + 50);
    check_end(0, s + 61, 4);

    // Six tiles, two cores; core 1 credit saturates under repeated fi
    s = cyc + 3;
    for (int k = 0; k < 4; k++) push_tile(1, k, s + 3 + 8 * k);
    push_tile(1, 4, s + 43);
    push_tile(1, 5, s + 63);
    start_run(1, 6, s);
    pulse_fi(1, 2'b10, s + 2);
    pulse_fi(1, 2'b10, s + 3);
    pulse_fi(1, 2'b10, s + 4);
    at(s + 38);
    chk("C stall core0", 64'(src_en2), 64'd0);
    pulse_fi(1, 2'b01, s + 40);
    chk("C tile4 src_addr", 64'(addr2), 64'd32);
    at(s + 55);
    chk("C stall core1", 64'(src_en2), 64'd0);
    pulse_fi(1, 2'b10, s + 60);
    check_end(1, s + 71, 6);

    // Reset at row 5 of tile 1, then a clean restart
    s = cyc + 3;
    push_tile(0, 0, s + 3);
    push_tile(0, 1, s + 11, 6);
    start_run(0, 2, s);
    at(s + 16);
    rst1 = 1'b1;
    at(s + 17);
    rst1 = 1'b0;
    chk("R src_en", 64'(src_en1), 64'd0);
    chk("R src_addr", 64'(addr1), 64'd0);
    chk("R row_vld", 64'({rv1, ev1}), 64'd0);
    chk("R busy/done", 64'({busy1, done1}), 64'd0);
    chk("R tile_cnt", 64'(cnt1), 64'd0);
    chk("R data", ug1 | pg1 | 64'(eu1), 64'd0);
    at(s + 30);
    chk("R queue drained", 64'(q1.size()), 64'd0);
    s = cyc + 3;
    push_tile(0, 0, s + 3);
    push_tile(0, 1, s + 11);
    start_run(0, 2, s);
    chk("R2 src_addr", 64'(addr1), 64'd0);
    check_end(0, s + 19, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
